text_renderer: RTL and testbench
================================

// Module: text_renderer
// PURPOSE
//  Parametrised text-mode pixel pipeline between VGAsyncGen and the VGA PMOD pins.
//  Owns a dual-port character+attribute buffer with a host write port and a clear-on-reset FSM.
//  Fetches glyph rows from an external 1-cycle font ROM.
//  Applies per-cell 16-colour fg/bg attributes, attribute blink and a blinking cursor.
//  Outputs 12-bit RGB with hsync/vsync/activevideo delayed to match pixel latency.
// PARAMETERS
//  CWIDTH       8    glyph width in pixels (power of 2)
//  CHEIGHT      16   glyph height in pixels (power of 2)
//  NCOL         80   text columns
//  NROW         30   text rows
//  CHAR_BITS    7    character code width
//  BLINK_FRAMES 30   frames per blink half-period (>=1)
//  CURSOR_MODE  0    0 = underline (glyph rows CHEIGHT-2..CHEIGHT-1), 1 = full block
//  SYNC_IDLE    1    inactive level of hsync/vsync (1 = negative-polarity sync)
// PORTS
//  clk          in   1          pixel clock (25 MHz)
//  rstn         in   1          asynchronous active-low reset
//  x_px         in   10         current pixel X from VGAsyncGen
//  y_px         in   10         current pixel Y from VGAsyncGen
//  activevideo  in   1          visible-area flag from VGAsyncGen
//  hsync_in     in   1          hsync from VGAsyncGen
//  vsync_in     in   1          vsync from VGAsyncGen
//  wr_en        in   1          host write request
//  wr_ready     out  1          buffer accepts writes (low while clearing)
//  wr_col       in   clog2(NCOL)  write column
//  wr_row       in   clog2(NROW)  write row
//  wr_char      in   CHAR_BITS  character code
//  wr_attr      in   8          {blink, bg[2:0], fg[3:0]}
//  cursor_en    in   1          cursor display enable
//  cursor_col   in   clog2(NCOL)  cursor column
//  cursor_row   in   clog2(NROW)  cursor row
//  font_addr    out  CHAR_BITS+clog2(CHEIGHT)  {char, glyph row} to font ROM
//  font_data    in   CWIDTH     glyph row, MSB = leftmost pixel, valid 1 cycle after font_addr
//  rgb          out  12         {R[3:0], G[3:0], B[3:0]}
//  hsync, vsync out  1          delayed syncs
//  active_out   out  1          delayed activevideo
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - rgb=0, active_out=0, hsync=vsync=SYNC_IDLE, pipeline valids 0.
//   - blink counter and phase 0; FSM enters CLEAR with addr=0; wr_ready=0.
//  FSM CLEAR:
//   - writes {0x20, 0x07} at one address per cycle, 0..NCOL*NROW-1.
//   - after the last address -> IDLE, wr_ready=1. CLEAR lasts NCOL*NROW cycles.
//   - wr_en during CLEAR is ignored (not queued).
//   - reset mid-CLEAR restarts at address 0.
//  FSM IDLE: write accepted when wr_en && wr_ready.
//   - stored at wr_row*NCOL+wr_col; visible to reads from the next cycle.
//   - writes with wr_col>=NCOL or wr_row>=NROW are dropped silently.
//  Rendering pipeline; latency is 3 clocks from x_px/y_px to rgb.
//   - S0: col=x_px/CWIDTH, row=y_px/CHEIGHT; buffer read issued at row*NCOL+col.
//     Column and row beyond range read as blank (code 0x20, attr 0).
//   - S1: font_addr={char, y_px%CHEIGHT}; carry attr, x%CWIDTH and the cursor hit forward.
//   - S2: bit = font_data[CWIDTH-1-xi]; pick fg/bg; rgb <= active ? palette(idx) : 0.
//   - hsync, vsync and activevideo pass through the same 3-stage delay.
//   - Same-cycle write and read to one address: the read returns the OLD data.
//  Colour selection:
//   - fg index = attr[3:0]; bg index = {0, attr[6:4]}.
//   - If attr[7] && blink_phase: pixel forced to bg.
//   - Cursor hit: cursor_en && col==cursor_col && row==cursor_row && blink_phase==0
//     && (CURSOR_MODE || glyph row >= CHEIGHT-2). A cursor hit swaps fg and bg.
//  Palette: fixed CGA-16, idx -> 12-bit colour.
//   - 0=000, 1=00A, 2=0A0, 3=0AA, 4=A00, 5=A0A, 6=A50, 7=AAA,
//     8=555, 9=55F, A=5F5, B=5FF, C=F55, D=F5F, E=FF5, F=FFF.
//  Blink:
//   - vsync_in leaving SYNC_IDLE counts one frame.
//   - Counter wraps at BLINK_FRAMES-1 and toggles blink_phase.
// TESTING
//  1. Reset release -> wr_ready low for exactly 2400 cycles (80x30), then high; all cells render {0x20, 0x07}.
//  2. Write 'A' (0x41), attr 0x1E at col 0, row 0; font ROM model returns 0x80 for every row.
//     -> rgb=FF5 at x=0 and 00A at x=1..7, three clocks after x_px is applied.
//  3. Ramp x_px through activevideo 0->1 -> active_out and rgb rise 3 cycles later; hsync delayed exactly 3 cycles.
//  4. cursor_en=1 at (5,2), CURSOR_MODE=0 -> glyph rows 14-15 of cell (5,2) show swapped fg/bg;
//     after 30 vsync pulses the cursor is hidden.
//  5. Write with wr_col=80 or during CLEAR -> buffer unchanged.
//     Same-cycle write/read to one cell -> old value rendered, new value on the next frame.
//  6. Attr 0x87, glyph 0xFF -> AAA in blink_phase 0; 000 (bg) in phase 1.
//     Assert rstn mid-frame -> rgb=0 immediately and CLEAR restarts.

Source files
------------

// File: rtl/text_renderer.sv
// Text-mode pixel pipeline: character/attribute buffer with a clear-on-reset FSM,
// glyph fetch from an external 1-cycle font ROM, colour attributes, blink and cursor.
module text_renderer #(
  parameter int unsigned CWIDTH       = 8,
  parameter int unsigned CHEIGHT      = 16,
  parameter int unsigned NCOL         = 80,
  parameter int unsigned NROW         = 30,
  parameter int unsigned CHAR_BITS    = 7,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned CURSOR_MODE  = 0,
  parameter bit          SYNC_IDLE    = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [9:0]                             x_px,
  input  logic [9:0]                             y_px,
  input  logic                                   activevideo,
  input  logic                                   hsync_in,
  input  logic                                   vsync_in,
  input  logic                                   wr_en,
  output logic                                   wr_ready,
  input  logic [$clog2(NCOL)-1:0]                wr_col,
  input  logic [$clog2(NROW)-1:0]                wr_row,
  input  logic [CHAR_BITS-1:0]                   wr_char,
  input  logic [7:0]                             wr_attr,
  input  logic                                   cursor_en,
  input  logic [$clog2(NCOL)-1:0]                cursor_col,
  input  logic [$clog2(NROW)-1:0]                cursor_row,
  output logic [CHAR_BITS+$clog2(CHEIGHT)-1:0]   font_addr,
  input  logic [CWIDTH-1:0]                      font_data,
  output logic [11:0]                            rgb,
  output logic                                   hsync,
  output logic                                   vsync,
  output logic                                   active_out
);

  localparam int unsigned CwLog  = $clog2(CWIDTH);
  localparam int unsigned ChLog  = $clog2(CHEIGHT);
  localparam int unsigned Cells  = NCOL * NROW;
  localparam int unsigned Aw     = $clog2(Cells);
  localparam int unsigned WordW  = CHAR_BITS + 8;
  localparam int unsigned Bw     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {StClear, StIdle} state_e;

  function automatic logic [11:0] palette(input logic [3:0] idx);
    case (idx)
      4'h0:    return 12'h000;
      4'h1:    return 12'h00A;
      4'h2:    return 12'h0A0;
      4'h3:    return 12'h0AA;
      4'h4:    return 12'hA00;
      4'h5:    return 12'hA0A;
      4'h6:    return 12'hA50;
      4'h7:    return 12'hAAA;
      4'h8:    return 12'h555;
      4'h9:    return 12'h55F;
      4'hA:    return 12'h5F5;
      4'hB:    return 12'h5FF;
      4'hC:    return 12'hF55;
      4'hD:    return 12'hF5F;
      4'hE:    return 12'hFF5;
      default: return 12'hFFF;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Buffer write side: clear FSM owns the write port until the screen is blank.
  state_e            state_q, state_d;
  logic [Aw-1:0]     clr_addr_q, clr_addr_d;
  logic              mem_we;
  logic [Aw-1:0]     mem_waddr;
  logic [WordW-1:0]  mem_wdata;
  logic              host_in_range;
  logic [Aw-1:0]     host_addr;

  assign host_in_range = (32'(wr_col) < NCOL) && (32'(wr_row) < NROW);
  assign host_addr     = Aw'(32'(wr_row) * NCOL + 32'(wr_col));

  // FSM state and clear pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state and write-port mux; host writes are dropped (not queued) while clearing
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = 1'b0;
    mem_waddr  = host_addr;
    mem_wdata  = {wr_char, wr_attr};
    wr_ready   = 1'b0;
    case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = {CHAR_BITS'(32'h20), 8'h07};
        if (clr_addr_q == Aw'(Cells - 1)) begin
          state_d    = StIdle;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      StIdle: begin
        wr_ready = 1'b1;
        mem_we   = wr_en && host_in_range;
      end
      default: state_d = StClear;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Blink timebase: one tick per vsync leaving its idle level.
  logic          vs_prev_q;
  logic [Bw-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic          frame_tick;

  assign frame_tick = (vs_prev_q == SYNC_IDLE) && (vsync_in != SYNC_IDLE);

  // Frame counter toggling the blink phase every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_prev_q     <= SYNC_IDLE;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vs_prev_q <= vsync_in;
      if (frame_tick) begin
        if (blink_cnt_q == Bw'(BLINK_FRAMES - 1)) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S0: cell lookup
  int unsigned       col_idx, row_idx;
  logic              cell_oob;
  logic [Aw-1:0]     rd_addr;
  logic              cur_hit;
  logic [WordW-1:0]  mem [Cells];
  logic [WordW-1:0]  rd_q;

  // Cell coordinates, read address and cursor hit for the incoming pixel
  always_comb begin
    col_idx  = 32'(x_px) >> CwLog;
    row_idx  = 32'(y_px) >> ChLog;
    cell_oob = (col_idx >= NCOL) || (row_idx >= NROW);
    rd_addr  = cell_oob ? '0 : Aw'(row_idx * NCOL + col_idx);
    cur_hit  = cursor_en && (col_idx == 32'(cursor_col)) && (row_idx == 32'(cursor_row)) &&
               !blink_phase_q &&
               ((CURSOR_MODE != 0) || (32'(y_px[ChLog-1:0]) >= CHEIGHT - 2));
  end

  // Buffer storage; the read sees pre-write contents on an address collision
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_q <= mem[rd_addr];
  end

  // S1/S2 pipeline registers
  logic              s1_oob, s1_cur;
  logic [ChLog-1:0]  s1_grow;
  logic [CwLog-1:0]  s1_xi;
  logic [CHAR_BITS-1:0] s1_char;
  logic [7:0]        s1_attr, s2_attr;
  logic [CwLog-1:0]  s2_xi;
  logic              s2_cur;
  logic [2:0]        act_q, hs_q, vs_q;
  logic              pix_bit;
  logic [3:0]        fg_idx, bg_idx, col_sel;

  assign s1_char   = s1_oob ? CHAR_BITS'(32'h20) : rd_q[WordW-1:8];
  assign s1_attr   = s1_oob ? 8'h00 : rd_q[7:0];
  assign font_addr = {s1_char, s1_grow};

  // S2 colour pick: attribute blink blanks the glyph, cursor swaps fg/bg
  always_comb begin
    fg_idx  = s2_attr[3:0];
    bg_idx  = {1'b0, s2_attr[6:4]};
    pix_bit = font_data[CwLog'(CWIDTH - 1) - s2_xi];
    if (s2_attr[7] && blink_phase_q) pix_bit = 1'b0;
    col_sel = (pix_bit ^ s2_cur) ? fg_idx : bg_idx;
  end

  // Pixel pipeline and matching 3-stage sync/active delay
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_oob  <= 1'b0;
      s1_cur  <= 1'b0;
      s1_grow <= '0;
      s1_xi   <= '0;
      s2_attr <= '0;
      s2_xi   <= '0;
      s2_cur  <= 1'b0;
      act_q   <= '0;
      hs_q    <= {3{SYNC_IDLE}};
      vs_q    <= {3{SYNC_IDLE}};
      rgb     <= '0;
    end else begin
      s1_oob  <= cell_oob;
      s1_cur  <= cur_hit;
      s1_grow <= y_px[ChLog-1:0];
      s1_xi   <= x_px[CwLog-1:0];
      s2_attr <= s1_attr;
      s2_xi   <= s1_xi;
      s2_cur  <= s1_cur;
      act_q   <= {act_q[1:0], activevideo};
      hs_q    <= {hs_q[1:0], hsync_in};
      vs_q    <= {vs_q[1:0], vsync_in};
      rgb     <= act_q[1] ? palette(col_sel) : 12'h000;
    end
  end

  assign hsync      = hs_q[2];
  assign vsync      = vs_q[2];
  assign active_out = act_q[2];

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer: random and directed pixel streams against a
// screen-level reference model (shadow character buffer, frame counter, CGA palette).
module tb_text_renderer;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [9:0]  x_px = '0, y_px = '0;
  logic        activevideo = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic        wr_en = 1'b0;
  logic        wr_ready;
  logic [6:0]  wr_col = '0;
  logic [4:0]  wr_row = '0;
  logic [6:0]  wr_char = '0;
  logic [7:0]  wr_attr = '0;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [4:0]  cursor_row = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [11:0] rgb;
  logic        hsync, vsync, active_out;

  text_renderer dut (
    .clk(clk), .rstn(rstn), .x_px(x_px), .y_px(y_px), .activevideo(activevideo),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char), .wr_attr(wr_attr),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .font_addr(font_addr), .font_data(font_data), .rgb(rgb), .hsync(hsync),
    .vsync(vsync), .active_out(active_out)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] PAL [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A,
                                       12'hA50, 12'hAAA, 12'h555, 12'h55F, 12'h5F5, 12'h5FF,
                                       12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  int checks = 0;
  int errors = 0;
  int font_mode = 2;
  logic [6:0]  m_char [2400];
  logic [7:0]  m_attr [2400];
  int          blink_cnt, phase, clear_left;
  logic        vs_prev;
  logic [11:0] e_rgb [3];
  logic        e_hs [3], e_vs [3], e_act [3];
  int          low;

  function automatic logic [7:0] font_fn(input logic [6:0] ch, input logic [3:0] gr);
    case (font_mode)
      0:       return 8'h80;
      1:       return 8'hFF;
      default: return 8'((int'(ch) * 29 + int'(gr) * 77) ^ 'h5A);
    endcase
  endfunction

  // External 1-cycle font ROM
  always @(posedge clk) font_data <= font_fn(font_addr[10:4], font_addr[3:0]);

  // Expected colour of one pixel from the screen contents as the bench sees them
  function automatic logic [11:0] exp_px(input int x, input int y, input bit av);
    int col, row, gr, xi;
    logic [6:0] ch;
    logic [7:0] at, g;
    bit on, cur;
    if (!av) return 12'h000;
    col = x / 8; row = y / 16; gr = y % 16; xi = x % 8;
    if (col < 80 && row < 30) begin
      ch = m_char[row * 80 + col];
      at = m_attr[row * 80 + col];
    end else begin
      ch = 7'h20;
      at = 8'h00;
    end
    g  = font_fn(ch, 4'(gr));
    on = g[7 - xi];
    if (at[7] && phase != 0) on = 1'b0;
    cur = cursor_en && col == int'(cursor_col) && row == int'(cursor_row) && phase == 0 &&
          gr >= 14;
    return PAL[(on ^ cur) ? at[3:0] : {1'b0, at[6:4]}];
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One pixel clock: check outputs due now, then drive the next inputs and update the model
  task automatic step(input int x, input int y, input bit av, input bit hs, input bit vs,
                      input bit we, input int wc, input int wr, input logic [6:0] ch,
                      input logic [7:0] at);
    @(negedge clk);
    if (clear_left > 0) clear_left--;
    chk("wr_ready", {11'b0, wr_ready}, {11'b0, clear_left == 0});
    chk("rgb", rgb, e_rgb[2]);
    chk("hsync", {11'b0, hsync}, {11'b0, e_hs[2]});
    chk("vsync", {11'b0, vsync}, {11'b0, e_vs[2]});
    chk("active_out", {11'b0, active_out}, {11'b0, e_act[2]});
    for (int i = 2; i > 0; i--) begin
      e_rgb[i] = e_rgb[i-1]; e_hs[i] = e_hs[i-1]; e_vs[i] = e_vs[i-1]; e_act[i] = e_act[i-1];
    end
    e_rgb[0] = exp_px(x, y, av); e_hs[0] = hs; e_vs[0] = vs; e_act[0] = av;
    x_px = 10'(x); y_px = 10'(y); activevideo = av; hsync_in = hs; vsync_in = vs;
    wr_en = we; wr_col = 7'(wc); wr_row = 5'(wr); wr_char = ch; wr_attr = at;
    if (we && clear_left == 0 && wc < 80 && wr < 30) begin
      m_char[wr * 80 + wc] = ch;
      m_attr[wr * 80 + wc] = at;
    end
    if (vs_prev && !vs) begin
      blink_cnt++;
      if (blink_cnt == 30) begin
        blink_cnt = 0;
        phase ^= 1;
      end
    end
    vs_prev = vs;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 7'h0, 8'h0);
  endtask

  task automatic px(input int x, input int y);
    step(x, y, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 7'h0, 8'h0);
  endtask

  task automatic wr(input int c, input int r, input logic [6:0] ch, input logic [7:0] at);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, c, r, ch, at);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 7'h0, 8'h0);
      step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 7'h0, 8'h0);
      step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 7'h0, 8'h0);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    x_px = '0; y_px = '0; activevideo = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; wr_en = 1'b0;
    for (int i = 0; i < 2400; i++) begin
      m_char[i] = 7'h20;
      m_attr[i] = 8'h07;
    end
    phase = 0; blink_cnt = 0; vs_prev = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e_rgb[i] = 12'h000; e_hs[i] = 1'b1; e_vs[i] = 1'b1; e_act[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    clear_left = 2400;
  endtask

  task automatic check_reset_now(input string tag);
    chk({tag, "_rgb"}, rgb, 12'h000);
    chk({tag, "_active"}, {11'b0, active_out}, 12'h000);
    chk({tag, "_hsync"}, {11'b0, hsync}, 12'h001);
    chk({tag, "_vsync"}, {11'b0, vsync}, 12'h001);
    chk({tag, "_wr_ready"}, {11'b0, wr_ready}, 12'h000);
  endtask

  initial begin
    // Reset values, then the clear sweep length
    #2 rstn = 1'b0;
    #1 check_reset_now("reset");
    do_reset();
    low = 0;
    repeat (2410) begin
      idle(1);
      if (wr_ready !== 1'b1) low++;
    end
    chk("clear_len", 12'(low + 1), 12'd2400);

    // Blank screen with a hashed font, including off-screen cells
    repeat (40) px($urandom_range(0, 639), $urandom_range(0, 479));
    px(700, 500);
    px(1000, 20);
    idle(3);

    // 'A' with attr 0x1E and a single-pixel font column
    font_mode = 0;
    idle(3);
    wr(0, 0, 7'h41, 8'h1E);
    for (int x = 0; x < 8; x++) px(x, 0);
    idle(3);

    // activevideo ramp with a toggling hsync
    for (int i = 0; i < 12; i++)
      step(100 + i, 40, i >= 5, (i % 3) != 0, 1'b1, 1'b0, 0, 0, 7'h0, 8'h0);
    idle(3);

    // Cursor at (5,2) and a blinking cell, solid glyph, both blink phases
    font_mode = 1;
    idle(3);
    cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd2;
    wr(10, 3, 7'h41, 8'h87);
    for (int pass = 0; pass < 3; pass++) begin
      for (int gr = 12; gr < 16; gr++) begin
        px(40 + gr % 8, 32 + gr);
        px(48, 32 + gr);
      end
      for (int x = 80; x < 84; x++) px(x, 48);
      idle(3);
      frames(30);
    end

    // Dropped out-of-range write, then same-cycle write/read collision
    font_mode = 2;
    idle(3);
    wr(80, 1, 7'h11, 8'h4F);
    for (int x = 0; x < 8; x++) px(x, 32);
    step(24, 64, 1'b1, 1'b1, 1'b1, 1'b1, 3, 4, 7'h5A, 8'h2C);
    for (int x = 24; x < 32; x++) px(x, 64);
    idle(3);

    // Random writes (some out of range) and random pixels over the written region
    repeat (40)
      wr(($urandom_range(0, 9) == 0) ? $urandom_range(80, 84) : $urandom_range(0, 15),
         $urandom_range(0, 3), 7'($urandom), 8'($urandom));
    repeat (150) px($urandom_range(0, 127), $urandom_range(0, 63));
    idle(3);
    frames(30);
    repeat (100) px($urandom_range(0, 127), $urandom_range(0, 63));
    for (int i = 0; i < 4; i++) px(8 * i, 3);

    // Asynchronous reset mid-frame, then a write attempt while clearing
    #2 rstn = 1'b0;
    #1 check_reset_now("midreset");
    cursor_en = 1'b0;
    do_reset();
    idle(100);
    wr(1, 1, 7'h55, 8'h4E);
    idle(2320);
    for (int x = 8; x < 16; x++) px(x, 17);
    for (int x = 80; x < 84; x++) px(x, 48);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
